vedic_seq_mult16: RTL

VEDIC_SEQ_MULT16 -- requirements
Module: vedic_seq_mult16

---
 rtl/vedic_seq_mult16.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vedic_seq_mult16.sv
// Sequential 16x16 unsigned multiplier reusing one Vedic 8x8 core over four partial products.
// Optional ZERO_SKIP_EN: a start with a zero operand bypasses CALC and completes immediately.

module vedic2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;
  assign c1   = a[1] & b[0] & a[0] & b[1];
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2] = c1 ^ (a[1] & b[1]);
  assign p[3] = c1 & a[1] & b[1];
endmodule

module vedic4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;
  vedic2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q0));
  vedic2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q1));
  vedic2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q2));
  vedic2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q3));
  assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

module vedic8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;
  vedic4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(q0));
  vedic4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(q1));
  vedic4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(q2));
  vedic4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(q3));
  assign p = {8'b0, q0} + {4'b0, q1, 4'b0} + {4'b0, q2, 4'b0} + {q3, 8'b0};
endmodule

module vedic_seq_mult16 #(
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] prod
);
  // state | meaning
  // IDLE  | waiting for start
  // CALC  | accumulating partial products, step_q = 0..3
  // DONE  | prod valid; one cycle (pulse) or until next start (level)
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [1:0]  step_q;
  logic [15:0] a_q, b_q;
  logic [31:0] acc_q, acc_d, prod_q;
  logic [7:0]  op_a, op_b;
  logic [15:0] pp;
  logic [31:0] pp_shift;

  // step[1] picks the high byte of a, step[0] the high byte of b
  assign op_a = step_q[1] ? a_q[15:8] : a_q[7:0];
  assign op_b = step_q[0] ? b_q[15:8] : b_q[7:0];

  vedic8x8 u_core (.a(op_a), .b(op_b), .p(pp));

  always_comb begin
    pp_shift = 32'd0;
    case (step_q)
      2'd0:    pp_shift = {16'd0, pp};
      2'd3:    pp_shift = {pp, 16'd0};
      default: pp_shift = {8'd0, pp, 8'd0};
    endcase
    acc_d = acc_q + pp_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      acc_q   <= 32'd0;
      prod_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= 32'd0;
            step_q <= 2'd0;
`ifdef ZERO_SKIP_EN
            if (a == 16'd0 || b == 16'd0) begin
              prod_q  <= 32'd0;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end else if (state_q == DONE && DONE_PULSE) begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) begin
            prod_q  <= acc_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign prod = prod_q;
endmodule
